// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide unit with busy/done handshake
// Shift-add multiply and restoring divide on operand magnitudes, sign-fixed at the end.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int STEPS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW       = $clog2(STEPS);
  localparam logic [CW-1:0]   LAST     = CW'(STEPS - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_n;

  logic [2:0]        op;
  logic              neg_a, neg_b, special;
  logic [XLEN-1:0]   spec_val, mag_b;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     count;
  logic              accept;

  logic              signed_a, signed_b, in_neg_a, in_neg_b, in_special;
  logic [XLEN-1:0]   in_mag_a, in_mag_b, in_spec_val;

  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ok;
  logic [XLEN-1:0]   div_diff;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  // Operand decode: signedness, magnitudes and the divide special cases.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      3'b010:  signed_a = 1'b1;
      default: ;
    endcase
    in_neg_a    = signed_a & a[XLEN-1];
    in_neg_b    = signed_b & b[XLEN-1];
    in_mag_a    = in_neg_a ? -a : a;
    in_mag_b    = in_neg_b ? -b : b;
    in_special  = 1'b0;
    in_spec_val = '0;
    if (funct3[2]) begin
      if (b == '0) begin
        in_special  = 1'b1;
        in_spec_val = funct3[1] ? a : ALL_ONES;
      end else if (!funct3[0] && a == MIN_NEG && b == ALL_ONES) begin
        in_special  = 1'b1;
        in_spec_val = funct3[1] ? '0 : MIN_NEG;
      end
    end
  end

  // One iteration: acc holds {partial_hi, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ok    = div_shift >= {1'b0, mag_b};
    div_diff  = div_shift[XLEN-1:0] - mag_b;
  end

  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quot_fix = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (special)
      fix_val = spec_val;
    else if (op[2])
      fix_val = op[1] ? rem_fix : quot_fix;
    else if (op[1:0] == 2'b00)
      fix_val = prod_fix[XLEN-1:0];
    else
      fix_val = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    busy    = (state != IDLE);
    done    = (state == DONE);
    case (state)
      IDLE: begin
        if (start && !flush) begin
          accept  = 1'b1;
          state_n = in_special ? FIX : CALC;
        end
      end
      CALC: begin
        if (flush)              state_n = IDLE;
        else if (count == LAST) state_n = FIX;
      end
      FIX:     state_n = flush ? IDLE : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      special  <= 1'b0;
      spec_val <= '0;
      mag_b    <= '0;
      acc      <= '0;
      count    <= '0;
      result   <= '0;
    end else begin
      if (accept) begin
        op       <= funct3;
        neg_a    <= in_neg_a;
        neg_b    <= in_neg_b;
        special  <= in_special;
        spec_val <= in_spec_val;
        mag_b    <= in_mag_b;
        acc      <= {{XLEN{1'b0}}, in_mag_a};
        count    <= '0;
      end else if (state == CALC) begin
        count <= count + 1'b1;
        if (op[2])
          acc <= {(div_ok ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ok};
        else
          acc <= {mul_sum, acc[XLEN-1:1]};
      end
      // result only moves on a completed operation; a flush in FIX leaves it intact
      if (state == FIX && !flush)
        result <= fix_val;
    end
  end

endmodule
